// File: rtl/aes_spi_ctrl.sv
`timescale 1ns/1ps
// aes_spi_ctrl: sequencer between the SPI subordinate and the AES core (key load / encrypt / result capture).
// Optional build macro AES_CTRL_TIMEOUT_EN enables the WAIT-state timeout abort and err_tmo.
module aes_spi_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:257] rx_frame,
    input  logic         rx_done,
    input  logic         key_clr,
    input  logic         aes_done,
    input  logic [0:127] aes_out,
    output logic [0:255] key,
    output logic [1:0]   key_size,
    output logic [0:127] plaintext,
    output logic         aes_start,
    output logic [0:127] tx,
    output logic         tx_valid,
    output logic         key_valid,
    output logic         busy,
    output logic         err_hdr,
    output logic         err_ovr,
    output logic         err_tmo
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_KEYLD  = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]   state;
    logic [2:0]   state_next;
    logic         sync_meta;
    logic         sync_q;
    logic         sync_prev;
    logic         frame_event;
    logic         hdr_256;
    logic         hdr_192;
    logic         hdr_128;
    logic         dec_valid;
    logic         dec_is_key;
    logic [0:255] dec_key;
    logic [1:0]   dec_size;
    logic [0:255] pend_key;
    logic [1:0]   pend_size;
    logic [0:127] result_q;
    logic         timeout_hit;

    // rx_done comes from the sclk domain; the third flop only serves edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_meta <= rx_done;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
        end
    end

    assign frame_event = sync_q & ~sync_prev;
    assign busy        = (state != S_IDLE);

    assign hdr_256 = (rx_frame[0:1]     == 2'b10);
    assign hdr_192 = (rx_frame[64:65]   == 2'b01);
    assign hdr_128 = (rx_frame[128:129] == 2'b00);

    always_comb begin
        dec_valid  = 1'b1;
        dec_is_key = 1'b1;
        dec_key    = '0;
        dec_size   = 2'b00;
        if (hdr_256) begin
            dec_key  = rx_frame[2:257];
            dec_size = 2'b10;
        end else if (hdr_192) begin
            dec_key  = {rx_frame[66:257], 64'b0};
            dec_size = 2'b01;
        end else if (hdr_128) begin
            dec_is_key = ~key_valid;
            dec_key    = {rx_frame[130:257], 128'b0};
            dec_size   = 2'b00;
        end else begin
            dec_valid = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (frame_event) state_next = S_DECODE;
            S_DECODE: begin
                if (!dec_valid)     state_next = S_IDLE;
                else if (dec_is_key) state_next = S_KEYLD;
                else                 state_next = S_START;
            end
            S_KEYLD:  state_next = S_IDLE;
            S_START:  state_next = S_WAIT;
            S_WAIT: begin
                if (aes_done)         state_next = S_DONE;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Each state's register writes take effect on the edge that leaves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key       <= '0;
            key_size  <= 2'b00;
            key_valid <= 1'b0;
            plaintext <= '0;
            aes_start <= 1'b0;
            tx        <= '0;
            tx_valid  <= 1'b0;
            err_hdr   <= 1'b0;
            err_ovr   <= 1'b0;
            pend_key  <= '0;
            pend_size <= 2'b00;
            result_q  <= '0;
        end else begin
            aes_start <= 1'b0;
            if (key_clr) key_valid <= 1'b0;
            if (frame_event && (state != S_IDLE)) err_ovr <= 1'b1;
            case (state)
                S_DECODE: begin
                    if (!dec_valid) begin
                        err_hdr <= 1'b1;
                    end else if (dec_is_key) begin
                        pend_key  <= dec_key;
                        pend_size <= dec_size;
                    end else begin
                        plaintext <= rx_frame[130:257];
                    end
                end
                S_KEYLD: begin
                    key       <= pend_key;
                    key_size  <= pend_size;
                    key_valid <= 1'b1;
                end
                S_START: begin
                    aes_start <= 1'b1;
                    tx_valid  <= 1'b0;
                end
                S_WAIT: begin
                    if (aes_done) result_q <= aes_out;
                end
                S_DONE: begin
                    tx       <= result_q;
                    tx_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counter sits at zero outside WAIT, so it is already clear on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wait_cnt <= '0;
        else if (state != S_WAIT) wait_cnt <= '0;
        else                     wait_cnt <= wait_cnt + CNT_W'(1);
    end

    assign timeout_hit = (state == S_WAIT) && !aes_done && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          err_tmo <= 1'b0;
        else if (timeout_hit) err_tmo <= 1'b1;
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign err_tmo        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_spi_ctrl.sv
`timescale 1ns/1ps
// tb_aes_spi_ctrl: scoreboard bench for aes_spi_ctrl; expected ciphertexts are queued when data frames are sent.
module tb_aes_spi_ctrl;

    localparam logic [255:0] K256  = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [255:0] K256B = 256'hFFEEDDCCBBAA99887766554433221100_0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [191:0] K192  = 192'hF0E1D2C3B4A5968778695A4B3C2D1E0F_0123456789ABCDEF;
    localparam logic [127:0] P1    = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] C1    = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] PK    = 128'hDEADBEEF0BADF00DCAFEBABE12345678;
    localparam logic [127:0] P2    = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] P3    = 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0;

    logic         clk;
    logic         rst_n;
    logic [0:257] rx_frame;
    logic         rx_done;
    logic         key_clr;
    logic         aes_done;
    logic [0:127] aes_out;
    logic [0:255] key;
    logic [1:0]   key_size;
    logic [0:127] plaintext;
    logic         aes_start;
    logic [0:127] tx;
    logic         tx_valid;
    logic         key_valid;
    logic         busy;
    logic         err_hdr;
    logic         err_ovr;
    logic         err_tmo;

    logic         model_done, man_done;
    logic [127:0] model_out, man_out;
    logic         aes_respond;
    logic         tx_valid_q;
    logic [127:0] exp_q[$];
    int           vectors;
    int           miscompares;
    int           start_count;
    int           sc;
    logic [0:257] f;

    aes_spi_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_frame(rx_frame), .rx_done(rx_done),
        .key_clr(key_clr), .aes_done(aes_done), .aes_out(aes_out),
        .key(key), .key_size(key_size), .plaintext(plaintext), .aes_start(aes_start),
        .tx(tx), .tx_valid(tx_valid), .key_valid(key_valid), .busy(busy),
        .err_hdr(err_hdr), .err_ovr(err_ovr), .err_tmo(err_tmo)
    );

    assign aes_done = model_done | man_done;
    assign aes_out  = model_done ? model_out : man_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the AES core: a fixed known-answer vector, otherwise a simple reversible scramble.
    function automatic logic [127:0] aes_model(input logic [127:0] pt);
        if (pt == P1) return C1;
        return {pt[63:0], pt[127:64]} ^ 128'h5A5A5A5AA5A5A5A5_0123456789ABCDEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raises rx_done with a new frame on a falling edge, drops it three cycles later.
    task automatic applyStimulus(input logic [0:257] frame);
        @(negedge clk);
        rx_frame = frame;
        rx_done  = 1'b1;
        repeat (3) @(negedge clk);
        rx_done  = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", busy, 0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_key", key, 0);
        checkOutput("rst_key_size", key_size, 0);
        checkOutput("rst_plaintext", plaintext, 0);
        checkOutput("rst_aes_start", aes_start, 0);
        checkOutput("rst_tx", tx, 0);
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_key_valid", key_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_hdr", err_hdr, 0);
        checkOutput("rst_err_ovr", err_ovr, 0);
        checkOutput("rst_err_tmo", err_tmo, 0);
    endtask

    always @(negedge clk) begin
        if (aes_start) start_count++;
    end

    // AES responder: answers each start pulse ten cycles later and checks the DONE latency.
    always begin
        @(negedge clk);
        if (aes_respond && rst_n && aes_start) begin
            repeat (10) @(negedge clk);
            model_out  = aes_model(plaintext);
            model_done = 1'b1;
            @(negedge clk);
            model_done = 1'b0;
            checkOutput("tx_valid_pre", tx_valid, 0);
            @(negedge clk);
            checkOutput("tx_valid_lat", tx_valid, 1);
            checkOutput("idle_after_done", busy, 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && tx_valid && !tx_valid_q) begin
            if (exp_q.size() == 0) checkOutput("sb_unexpected", 1, 0);
            else checkOutput("sb_tx", tx, exp_q.pop_front());
        end
        tx_valid_q = tx_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; start_count = 0;
        rst_n = 1'b1; rx_frame = '0; rx_done = 1'b0; key_clr = 1'b0;
        man_done = 1'b0; man_out = '0; model_done = 1'b0; model_out = '0;
        aes_respond = 1'b1; tx_valid_q = 1'b0;
        #2 rst_n = 1'b0;
        tick(3);
        checkResetState();
        rst_n = 1'b1;
        tick(2);

        // 256-bit key frame, with key_valid latency
        f = '0; f[0:1] = 2'b10; f[2:257] = K256;
        sc = start_count;
        applyStimulus(f);
        tick(1);
        checkOutput("k256_valid_early", key_valid, 0);
        checkOutput("k256_busy", busy, 1);
        tick(1);
        checkOutput("k256_valid", key_valid, 1);
        checkOutput("k256_key", key, K256);
        checkOutput("k256_size", key_size, 2'b10);
        checkOutput("k256_no_start", start_count, sc);

        // Data frame with start-pulse timing; tx checked by the scoreboard
        f = '0; f[130:257] = P1;
        exp_q.push_back(aes_model(P1));
        applyStimulus(f);
        tick(1);
        checkOutput("start_early", aes_start, 0);
        tick(1);
        checkOutput("start_pulse", aes_start, 1);
        checkOutput("plaintext", plaintext, P1);
        tick(1);
        checkOutput("start_single", aes_start, 0);
        waitIdle(40);
        tick(2);

        // aes_done outside WAIT is ignored
        man_out = 128'hFFFF0000FFFF0000FFFF0000FFFF0000; man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(1);
        checkOutput("stray_done_tx", tx, C1);
        checkOutput("stray_done_valid", tx_valid, 1);
        checkOutput("stray_done_busy", busy, 0);

        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // First 128-bit frame after reset becomes a key
        f = '0; f[130:257] = PK;
        sc = start_count;
        applyStimulus(f);
        tick(2);
        checkOutput("k128_key", key, {PK, 128'b0});
        checkOutput("k128_size", key_size, 2'b00);
        checkOutput("k128_valid", key_valid, 1);
        checkOutput("k128_no_start", start_count, sc);
        key_clr = 1'b1;
        tick(1);
        key_clr = 1'b0;
        checkOutput("clr_valid", key_valid, 0);
        checkOutput("clr_key_kept", key, {PK, 128'b0});

        f = '0; f[64:65] = 2'b01; f[66:257] = K192;
        applyStimulus(f);
        tick(2);
        checkOutput("k192_size", key_size, 2'b01);
        checkOutput("k192_key", key, {K192, 64'b0});
        checkOutput("k192_valid", key_valid, 1);

        // Bad header
        f = '0; f[128:129] = 2'b11;
        applyStimulus(f);
        tick(2);
        checkOutput("hdr_err", err_hdr, 1);
        checkOutput("hdr_idle", busy, 0);
        checkOutput("hdr_key_kept", key, {K192, 64'b0});

        // key_clr coinciding with the KEYLD write
        key_clr = 1'b1;
        tick(1);
        key_clr = 1'b0;
        f = '0; f[0:1] = 2'b10; f[2:257] = K256B;
        applyStimulus(f);
        tick(1);
        key_clr = 1'b1;
        tick(1);
        key_clr = 1'b0;
        checkOutput("clr_vs_keyld", key_valid, 1);
        checkOutput("k256b_key", key, K256B);

        // Overrun during WAIT, plus key_clr that must not disturb the encryption
        aes_respond = 1'b0;
        f = '0; f[130:257] = P2;
        exp_q.push_back(aes_model(P2));
        applyStimulus(f);
        tick(2);
        f = '0; f[130:257] = P3;
        applyStimulus(f);
        tick(1);
        checkOutput("ovr_flag", err_ovr, 1);
        checkOutput("ovr_plaintext", plaintext, P2);
        checkOutput("ovr_busy", busy, 1);
        key_clr = 1'b1;
        tick(1);
        key_clr = 1'b0;
        man_out = aes_model(P2); man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        waitIdle(20);
        tick(1);
        checkOutput("wait_clr_valid", key_valid, 0);

        f = '0; f[0:1] = 2'b10; f[2:257] = K256;
        applyStimulus(f);
        tick(2);
        checkOutput("reload_valid", key_valid, 1);

        // Withheld aes_done
        f = '0; f[130:257] = P3;
        applyStimulus(f);
        tick(17);
`ifdef AES_CTRL_TIMEOUT_EN
        checkOutput("tmo_busy_before", busy, 1);
        checkOutput("tmo_flag_before", err_tmo, 0);
        tick(1);
        checkOutput("tmo_idle", busy, 0);
        checkOutput("tmo_flag", err_tmo, 1);
        checkOutput("tmo_tx_valid", tx_valid, 0);
        applyStimulus(f);
        tick(4);
`else
        tick(1);
        checkOutput("wait_holds", busy, 1);
        checkOutput("no_tmo", err_tmo, 0);
`endif
        checkOutput("wait_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        checkResetState();
        tick(2);
        rst_n = 1'b1;
        tick(2);

        checkOutput("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
